// File: rtl/alu_ctrl_stage_pkg.sv
// Shared MIPS opcode/funct fields, ALU control codes and mul/div FSM states for alu_ctrl_stage.
package alu_ctrl_stage_pkg;

  typedef enum logic {MdIdle = 1'b0, MdBusy = 1'b1} md_state_e;

  // Opcode field values
  localparam logic [5:0] EXE_SPECIAL = 6'b000000;
  localparam logic [5:0] EXE_ANDI    = 6'b001100;
  localparam logic [5:0] EXE_ORI     = 6'b001101;
  localparam logic [5:0] EXE_XORI    = 6'b001110;
  localparam logic [5:0] EXE_LUI     = 6'b001111;
  localparam logic [5:0] EXE_ADDI    = 6'b001000;
  localparam logic [5:0] EXE_ADDIU   = 6'b001001;
  localparam logic [5:0] EXE_SLTI    = 6'b001010;
  localparam logic [5:0] EXE_SLTIU   = 6'b001011;
  localparam logic [5:0] EXE_LW      = 6'b100011;
  localparam logic [5:0] EXE_SW      = 6'b101011;
  localparam logic [5:0] EXE_BEQ     = 6'b000100;

  // Funct field values (op == EXE_SPECIAL)
  localparam logic [5:0] EXE_AND   = 6'b100100;
  localparam logic [5:0] EXE_OR    = 6'b100101;
  localparam logic [5:0] EXE_XOR   = 6'b100110;
  localparam logic [5:0] EXE_NOR   = 6'b100111;
  localparam logic [5:0] EXE_SLL   = 6'b000000;
  localparam logic [5:0] EXE_SLLV  = 6'b000100;
  localparam logic [5:0] EXE_SRL   = 6'b000010;
  localparam logic [5:0] EXE_SRLV  = 6'b000110;
  localparam logic [5:0] EXE_SRA   = 6'b000011;
  localparam logic [5:0] EXE_SRAV  = 6'b000111;
  localparam logic [5:0] EXE_MFHI  = 6'b010000;
  localparam logic [5:0] EXE_MTHI  = 6'b010001;
  localparam logic [5:0] EXE_MFLO  = 6'b010010;
  localparam logic [5:0] EXE_MTLO  = 6'b010011;
  localparam logic [5:0] EXE_SLT   = 6'b101010;
  localparam logic [5:0] EXE_SLTU  = 6'b101011;
  localparam logic [5:0] EXE_ADD   = 6'b100000;
  localparam logic [5:0] EXE_ADDU  = 6'b100001;
  localparam logic [5:0] EXE_SUB   = 6'b100010;
  localparam logic [5:0] EXE_SUBU  = 6'b100011;
  localparam logic [5:0] EXE_MULT  = 6'b011000;
  localparam logic [5:0] EXE_MULTU = 6'b011001;
  localparam logic [5:0] EXE_DIV   = 6'b011010;
  localparam logic [5:0] EXE_DIVU  = 6'b011011;

  // ALU control codes
  localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [7:0] EXE_ANDI_OP  = 8'b01011001;
  localparam logic [7:0] EXE_ORI_OP   = 8'b01011010;
  localparam logic [7:0] EXE_XORI_OP  = 8'b01011011;
  localparam logic [7:0] EXE_LUI_OP   = 8'b01011100;
  localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [7:0] EXE_SLLV_OP  = 8'b00000100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [7:0] EXE_SRLV_OP  = 8'b00000110;
  localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [7:0] EXE_SRAV_OP  = 8'b00000111;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
  localparam logic [7:0] EXE_SLTI_OP  = 8'b01010111;
  localparam logic [7:0] EXE_SLTIU_OP = 8'b01011000;
  localparam logic [7:0] EXE_ADD_OP   = 8'b00100000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b00100010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b01010101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b01010110;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [7:0] EXE_LW_OP    = 8'b11100011;
  localparam logic [7:0] EXE_SW_OP    = 8'b11101011;
  localparam logic [7:0] EXE_BEQ_OP   = 8'b01010001;

  function automatic logic is_muldiv_funct(input logic [5:0] funct);
    return funct inside {EXE_MULT, EXE_MULTU, EXE_DIV, EXE_DIVU};
  endfunction

  function automatic logic is_hilo_funct(input logic [5:0] funct);
    return funct inside {EXE_MFHI, EXE_MFLO, EXE_MTHI, EXE_MTLO};
  endfunction

  function automatic logic is_div_funct(input logic [5:0] funct);
    return funct inside {EXE_DIV, EXE_DIVU};
  endfunction

endpackage

// File: rtl/alu_ctrl_stage_decode.sv
// Combinational op/funct -> ALU control decoder (module alu_ctrl_decode).
module alu_ctrl_decode
  import alu_ctrl_stage_pkg::*;
#(
  parameter int unsigned CTRL_W = 8
) (
  input  logic [5:0]        op_i,
  input  logic [5:0]        funct_i,
  output logic [CTRL_W-1:0] alucontrol_o,
  output logic              is_muldiv_o,
  output logic              is_hilo_o,
  output logic              illegal_o
);

  logic [7:0] code;
  logic       special;

  assign special = (op_i == EXE_SPECIAL);

  always_comb begin
    code      = 8'h00;
    illegal_o = 1'b0;
    if (special) begin
      unique case (funct_i)
        EXE_AND:   code = EXE_AND_OP;
        EXE_OR:    code = EXE_OR_OP;
        EXE_XOR:   code = EXE_XOR_OP;
        EXE_NOR:   code = EXE_NOR_OP;
        EXE_SLL:   code = EXE_SLL_OP;
        EXE_SLLV:  code = EXE_SLLV_OP;
        EXE_SRL:   code = EXE_SRL_OP;
        EXE_SRLV:  code = EXE_SRLV_OP;
        EXE_SRA:   code = EXE_SRA_OP;
        EXE_SRAV:  code = EXE_SRAV_OP;
        EXE_MFHI:  code = EXE_MFHI_OP;
        EXE_MTHI:  code = EXE_MTHI_OP;
        EXE_MFLO:  code = EXE_MFLO_OP;
        EXE_MTLO:  code = EXE_MTLO_OP;
        EXE_SLT:   code = EXE_SLT_OP;
        EXE_SLTU:  code = EXE_SLTU_OP;
        EXE_ADD:   code = EXE_ADD_OP;
        EXE_ADDU:  code = EXE_ADDU_OP;
        EXE_SUB:   code = EXE_SUB_OP;
        EXE_SUBU:  code = EXE_SUBU_OP;
        EXE_MULT:  code = EXE_MULT_OP;
        EXE_MULTU: code = EXE_MULTU_OP;
        EXE_DIV:   code = EXE_DIV_OP;
        EXE_DIVU:  code = EXE_DIVU_OP;
        default:   illegal_o = 1'b1;
      endcase
    end else begin
      unique case (op_i)
        EXE_ANDI:  code = EXE_ANDI_OP;
        EXE_ORI:   code = EXE_ORI_OP;
        EXE_XORI:  code = EXE_XORI_OP;
        EXE_LUI:   code = EXE_LUI_OP;
        EXE_ADDI:  code = EXE_ADDI_OP;
        EXE_ADDIU: code = EXE_ADDIU_OP;
        EXE_SLTI:  code = EXE_SLTI_OP;
        EXE_SLTIU: code = EXE_SLTIU_OP;
        EXE_LW:    code = EXE_LW_OP;
        EXE_SW:    code = EXE_SW_OP;
        EXE_BEQ:   code = EXE_BEQ_OP;
        default:   illegal_o = 1'b1;
      endcase
    end
  end

  assign alucontrol_o = CTRL_W'(code);
  assign is_muldiv_o  = special && is_muldiv_funct(funct_i);
  assign is_hilo_o    = special && is_hilo_funct(funct_i);

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ID->EX ALU-control stage with valid/ready handshake, flush and mul/div busy tracker.
// Define ALUCTRL_PERF_EN to add the stall_cycles / md_ops performance counters.
module alu_ctrl_stage
  import alu_ctrl_stage_pkg::*;
#(
  parameter int unsigned CTRL_W  = 8,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 36
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [5:0]        id_funct,
  output logic              id_ready,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_alucontrol,
  output logic              ex_is_muldiv,
  output logic              ex_illegal,
  output logic              md_busy,
  output logic              md_done
`ifdef ALUCTRL_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       md_ops
`endif
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  logic [CTRL_W-1:0] dec_alucontrol;
  logic              dec_is_muldiv, dec_is_hilo, dec_illegal;
  logic              hold, accept;

  logic              ex_valid_q, ex_valid_d;
  logic [CTRL_W-1:0] ex_alu_q, ex_alu_d;
  logic              ex_muldiv_q, ex_muldiv_d;
  logic              ex_illegal_q, ex_illegal_d;
  md_state_e         md_state_q, md_state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              md_done_q, md_done_d;

  alu_ctrl_decode #(
    .CTRL_W(CTRL_W)
  ) u_decode (
    .op_i        (id_op),
    .funct_i     (id_funct),
    .alucontrol_o(dec_alucontrol),
    .is_muldiv_o (dec_is_muldiv),
    .is_hilo_o   (dec_is_hilo),
    .illegal_o   (dec_illegal)
  );

  assign md_busy  = (md_state_q == MdBusy);
  assign hold     = md_busy && (dec_is_muldiv || dec_is_hilo);
  assign id_ready = (!ex_valid_q || ex_ready) && !hold && !flush;
  assign accept   = id_valid && id_ready;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_alu_d     = ex_alu_q;
    ex_muldiv_d  = ex_muldiv_q;
    ex_illegal_d = ex_illegal_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d   = 1'b1;
      ex_alu_d     = dec_alucontrol;
      ex_muldiv_d  = dec_is_muldiv;
      ex_illegal_d = dec_illegal;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_comb begin
    md_state_d = md_state_q;
    cnt_d      = cnt_q;
    md_done_d  = 1'b0;
    if (flush) begin
      // Aborted op: drop silently, no completion pulse.
      md_state_d = MdIdle;
      cnt_d      = '0;
    end else begin
      unique case (md_state_q)
        MdIdle: begin
          if (accept && dec_is_muldiv) begin
            md_state_d = MdBusy;
            cnt_d      = is_div_funct(id_funct) ? CntW'(DIV_LAT) : CntW'(MUL_LAT);
          end
        end
        MdBusy: begin
          if (cnt_q == CntW'(1)) begin
            md_state_d = MdIdle;
            cnt_d      = '0;
            md_done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: md_state_d = MdIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ex_valid_q   <= 1'b0;
      ex_alu_q     <= '0;
      ex_muldiv_q  <= 1'b0;
      ex_illegal_q <= 1'b0;
      md_state_q   <= MdIdle;
      cnt_q        <= '0;
      md_done_q    <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_alu_q     <= ex_alu_d;
      ex_muldiv_q  <= ex_muldiv_d;
      ex_illegal_q <= ex_illegal_d;
      md_state_q   <= md_state_d;
      cnt_q        <= cnt_d;
      md_done_q    <= md_done_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_alucontrol = ex_alu_q;
  assign ex_is_muldiv  = ex_muldiv_q;
  assign ex_illegal    = ex_illegal_q;
  assign md_done       = md_done_q;

`ifdef ALUCTRL_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] md_ops_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_q  <= '0;
      md_ops_q <= '0;
    end else begin
      if (id_valid && !id_ready && !flush) stall_q <= stall_q + 32'd1;
      if (md_done_q) md_ops_q <= md_ops_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign md_ops       = md_ops_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: driver queues expected EX outputs, monitor checks on consume.
module tb_alu_ctrl_stage;

  logic       clk = 1'b0;
  logic       resetn, id_valid, flush, ex_ready;
  logic [5:0] id_op, id_funct;
  logic       id_ready, ex_valid, ex_is_muldiv, ex_illegal, md_busy, md_done;
  logic [7:0] ex_alucontrol;
`ifdef ALUCTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] md_ops;
`endif

  typedef struct packed {
    logic [7:0] code;
    logic       muldiv;
    logic       illegal;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_err = 0, busy_cnt = 0, done_cnt = 0;
  int   w, b0, d0;
  logic d;

  always #5 clk = ~clk;

  alu_ctrl_stage #(
    .CTRL_W (8),
    .MUL_LAT(2),
    .DIV_LAT(36)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .id_valid     (id_valid),
    .id_op        (id_op),
    .id_funct     (id_funct),
    .id_ready     (id_ready),
    .flush        (flush),
    .ex_ready     (ex_ready),
    .ex_valid     (ex_valid),
    .ex_alucontrol(ex_alucontrol),
    .ex_is_muldiv (ex_is_muldiv),
    .ex_illegal   (ex_illegal),
    .md_busy      (md_busy),
    .md_done      (md_done)
`ifdef ALUCTRL_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .md_ops       (md_ops)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: counts busy/done cycles and checks every consumed EX output against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1) begin
      if (md_busy) busy_cnt++;
      if (md_done) done_cnt++;
      if (ex_valid && ex_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL ex_unexpected: got code %0h, required no output", ex_alucontrol);
        end else begin
          e = exp_q.pop_front();
          check("ex_alucontrol", {24'd0, ex_alucontrol}, {24'd0, e.code});
          check("ex_is_muldiv", {31'd0, ex_is_muldiv}, {31'd0, e.muldiv});
          check("ex_illegal", {31'd0, ex_illegal}, {31'd0, e.illegal});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction until accepted; report stalled cycles and md_done at the accept cycle.
  task automatic issue(input logic [5:0] op, input logic [5:0] funct, input logic [7:0] code,
                       input logic md, input logic ill, output int waits, output logic done_acc);
    logic got;
    exp_t e;
    got      = 1'b0;
    waits    = 0;
    done_acc = 1'b0;
    id_valid = 1'b1;
    id_op    = op;
    id_funct = funct;
    while (!got && waits < 100) begin
      @(negedge clk);
      if (id_ready === 1'b1) begin
        e = '{code: code, muldiv: md, illegal: ill};
        exp_q.push_back(e);
        done_acc = md_done;
        got      = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: op %0h funct %0h never accepted, required accept", op, funct);
    end
    step();
    id_valid = 1'b0;
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic [7:0] code;
    logic       ill;
  } vec_t;

  vec_t vecs[6] = '{
    '{6'h00, 6'h00, 8'h7C, 1'b0},  // SLL
    '{6'h0F, 6'h00, 8'h5C, 1'b0},  // LUI
    '{6'h2B, 6'h00, 8'hEB, 1'b0},  // SW
    '{6'h00, 6'h23, 8'h23, 1'b0},  // SUBU
    '{6'h23, 6'h00, 8'hE3, 1'b0},  // LW
    '{6'h00, 6'h3F, 8'h00, 1'b1}   // unknown funct
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset with an instruction pending, then ADD
    resetn   = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    id_valid = 1'b1;
    id_op    = 6'h00;
    id_funct = 6'h20;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ex_valid", {31'd0, ex_valid}, 0);
    check("rst_ex_alucontrol", {24'd0, ex_alucontrol}, 0);
    check("rst_ex_is_muldiv", {31'd0, ex_is_muldiv}, 0);
    check("rst_ex_illegal", {31'd0, ex_illegal}, 0);
    check("rst_md_busy", {31'd0, md_busy}, 0);
    check("rst_md_done", {31'd0, md_done}, 0);
    step();
    resetn = 1'b1;
    issue(6'h00, 6'h20, 8'h20, 1'b0, 1'b0, w, d);
    check("add_wait", w, 0);

    // 2. DIV then MFLO held until md_done
    b0 = busy_cnt;
    d0 = done_cnt;
    issue(6'h00, 6'h1A, 8'h1A, 1'b1, 1'b0, w, d);
    issue(6'h00, 6'h12, 8'h12, 1'b0, 1'b0, w, d);
    check("mflo_hold_cycles", w, 36);
    check("mflo_accept_in_done", {31'd0, d}, 1);
    repeat (3) step();
    check("div_busy_cycles", busy_cnt - b0, 36);
    check("div_done_pulses", done_cnt - d0, 1);
`ifdef ALUCTRL_PERF_EN
    check("perf_stall_cycles", stall_cycles, 36);
    check("perf_md_ops", {16'd0, md_ops}, 1);
`endif

    // 3. ORI stalled by ex_ready=0, then ADDI
    ex_ready = 1'b0;
    issue(6'h0D, 6'h00, 8'h5A, 1'b0, 1'b0, w, d);
    check("ori_wait", w, 0);
    id_valid = 1'b1;
    id_op    = 6'h08;
    id_funct = 6'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_id_ready", {31'd0, id_ready}, 0);
      check("stall_ex_valid", {31'd0, ex_valid}, 1);
      check("stall_ex_alucontrol", {24'd0, ex_alucontrol}, 32'h5A);
      step();
    end
    ex_ready = 1'b1;
    issue(6'h08, 6'h00, 8'h55, 1'b0, 1'b0, w, d);
    check("addi_after_release", w, 0);

    // decode table
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].funct, vecs[i].code, 1'b0, vecs[i].ill, w, d);
    end

    // 4. flush in busy cycle 10 of a DIV, with an ADD presented
    d0 = done_cnt;
    issue(6'h00, 6'h1A, 8'h1A, 1'b1, 1'b0, w, d);
    repeat (9) step();
    flush    = 1'b1;
    id_valid = 1'b1;
    id_op    = 6'h00;
    id_funct = 6'h20;
    @(negedge clk);
    check("flush_id_ready", {31'd0, id_ready}, 0);
    check("flush_busy_before", {31'd0, md_busy}, 1);
    step();
    flush    = 1'b0;
    id_valid = 1'b0;
    @(negedge clk);
    check("flush_md_busy", {31'd0, md_busy}, 0);
    check("flush_ex_valid", {31'd0, ex_valid}, 0);
    repeat (45) step();
    check("flush_no_done", done_cnt - d0, 0);

    // 5. illegal opcode, back-to-back MULT
    issue(6'h3F, 6'h00, 8'h00, 1'b0, 1'b1, w, d);
    d0 = done_cnt;
    issue(6'h00, 6'h18, 8'h18, 1'b1, 1'b0, w, d);
    issue(6'h00, 6'h18, 8'h18, 1'b1, 1'b0, w, d);
    check("mult2_wait", w, 2);
    check("mult2_accept_in_done", {31'd0, d}, 1);
    repeat (5) step();
    check("mult_done_pulses", done_cnt - d0, 2);

    // reset in the middle of a DIV discards it
    d0 = done_cnt;
    issue(6'h00, 6'h1B, 8'h1B, 1'b1, 1'b0, w, d);
    repeat (5) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_md_busy", {31'd0, md_busy}, 0);
    check("midrst_ex_valid", {31'd0, ex_valid}, 0);
    repeat (40) step();
    check("midrst_no_done", done_cnt - d0, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
